// File: rtl/eq_gain_regbank_if.sv
// Register-bus and gain-output bundle of the equalizer band-gain register bank.
// we, re and tick are single-cycle strobes with no ready/backpressure: the slave accepts every strobe on the rising edge where it is high.
interface eq_gain_regbank_if #(
    parameter int NUM_BANDS  = 10,
    parameter int GAIN_WIDTH = 13
);
    logic                            we;
    logic                            re;
    logic [7:0]                      addr;
    logic [7:0]                      data_in;
    logic                            tick;
    logic [7:0]                      rd_data;
    logic [NUM_BANDS*GAIN_WIDTH-1:0] gain;
    logic                            busy;

    modport master (
        output we, re, addr, data_in, tick,
        input  rd_data, gain, busy
    );

    modport slave (
        input  we, re, addr, data_in, tick,
        output rd_data, gain, busy
    );
endinterface

// File: rtl/eq_gain_regbank.sv
// Staged/committed per-band gain registers feeding the EQ filter-bank multipliers.
// Define GAIN_RAMP_EN to build the per-tick ramp engine between target and active gains.
module eq_gain_regbank #(
    parameter int NUM_BANDS  = 10,
    parameter int GAIN_WIDTH = 13,
    parameter int FRAC_BITS  = 8,
    parameter int RAMP_STEP  = 16
) (
    input logic              clk,
    input logic              rst,
    eq_gain_regbank_if.slave bus
);
    localparam int                    HI_W        = GAIN_WIDTH - 8;
    localparam logic [GAIN_WIDTH-1:0] UNITY       = GAIN_WIDTH'(1 << FRAC_BITS);
    localparam logic [7:0]            BAND_END    = 8'(2 * NUM_BANDS);
    localparam logic [7:0]            ADDR_CTRL   = 8'hF0;
    localparam logic [7:0]            ADDR_BYPASS = 8'hF1;
    localparam logic [7:0]            ADDR_STATUS = 8'hF2;

    logic [GAIN_WIDTH-1:0] s_q   [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] t_q   [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] c_cur [NUM_BANDS];
    logic                  bypass_q;
    logic                  busy_q;
    logic [7:0]            rd_q;
    logic [7:0]            rd_next;
    logic                  in_bands;
    logic [6:0]            band_sel;
    logic                  commit;
    logic                  stage_unity;

    assign in_bands    = bus.addr < BAND_END;
    assign band_sel    = bus.addr[7:1];
    assign commit      = bus.we && (bus.addr == ADDR_CTRL) && bus.data_in[0];
    assign stage_unity = bus.we && (bus.addr == ADDR_CTRL) && bus.data_in[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                s_q[b] <= UNITY;
                t_q[b] <= UNITY;
            end
            bypass_q <= 1'b0;
            rd_q     <= 8'h00;
        end else begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                // Commit samples the old staging value even when unity staging fires alongside it.
                if (commit) t_q[b] <= s_q[b];
                if (stage_unity) begin
                    s_q[b] <= UNITY;
                end else if (bus.we && in_bands && band_sel == 7'(b)) begin
                    if (bus.addr[0]) s_q[b][GAIN_WIDTH-1:8] <= bus.data_in[HI_W-1:0];
                    else             s_q[b][7:0]            <= bus.data_in;
                end
            end
            if (bus.we && bus.addr == ADDR_BYPASS) bypass_q <= bus.data_in[0];
            if (bus.re) rd_q <= rd_next;
        end
    end

    // Read mux sees pre-write state, so a same-cycle write to the read address is not visible yet.
    always_comb begin
        rd_next = 8'h00;
        if (in_bands) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (band_sel == 7'(b))
                    rd_next = bus.addr[0] ? 8'(s_q[b][GAIN_WIDTH-1:8]) : s_q[b][7:0];
            end
        end else if (bus.addr == ADDR_BYPASS) begin
            rd_next = {7'b0, bypass_q};
        end else if (bus.addr == ADDR_STATUS) begin
            rd_next = {7'b0, busy_q};
        end
    end

`ifdef GAIN_RAMP_EN
    localparam logic [GAIN_WIDTH:0] STEP = (GAIN_WIDTH+1)'(RAMP_STEP);

    logic [GAIN_WIDTH-1:0] c_q [NUM_BANDS];
    logic                  mismatch;

    // One bounded step toward t, one bit wider so the difference never wraps.
    function automatic logic [GAIN_WIDTH-1:0] ramp_next(input logic [GAIN_WIDTH-1:0] c,
                                                        input logic [GAIN_WIDTH-1:0] t);
        logic [GAIN_WIDTH:0] cw;
        logic [GAIN_WIDTH:0] tw;
        logic [GAIN_WIDTH:0] d;
        logic [GAIN_WIDTH:0] r;
        cw = {1'b0, c};
        tw = {1'b0, t};
        r  = cw;
        if (cw < tw) begin
            d = tw - cw;
            if (d > STEP) d = STEP;
            r = cw + d;
        end else if (cw > tw) begin
            d = cw - tw;
            if (d > STEP) d = STEP;
            r = cw - d;
        end
        return GAIN_WIDTH'(r);
    endfunction

    always_comb begin
        mismatch = 1'b0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (c_q[b] != t_q[b]) mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANDS; b++) c_q[b] <= UNITY;
            busy_q <= 1'b0;
        end else begin
            if (bus.tick) begin
                for (int b = 0; b < NUM_BANDS; b++) c_q[b] <= ramp_next(c_q[b], t_q[b]);
            end
            busy_q <= mismatch;
        end
    end

    assign c_cur = c_q;
`else
    localparam int unused_ramp_step = RAMP_STEP;
    logic          unused_tick;

    assign unused_tick = bus.tick;
    assign c_cur       = t_q;
    assign busy_q      = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_out
        assign bus.gain[b*GAIN_WIDTH +: GAIN_WIDTH] = bypass_q ? UNITY : c_cur[b];
    end

    assign bus.busy    = busy_q;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_eq_gain_regbank.sv
// Self-checking bench for eq_gain_regbank: directed scenarios plus randomized traffic against a
// behavioural register/ramp model; covers both GAIN_RAMP_EN builds.
`timescale 1ns/1ps
module tb_eq_gain_regbank;
    localparam int NB    = 10;
    localparam int GW    = 13;
    localparam int FB    = 8;
    localparam int RS    = 16;
    localparam int UNITY = 1 << FB;
    localparam int HMASK = (1 << (GW - 8)) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    eq_gain_regbank_if #(.NUM_BANDS(NB), .GAIN_WIDTH(GW)) bus();

    eq_gain_regbank #(
        .NUM_BANDS(NB), .GAIN_WIDTH(GW), .FRAC_BITS(FB), .RAMP_STEP(RS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         s_m [NB];
    int         t_m [NB];
    int         c_m [NB];
    bit         byp_m;
    bit         busy_m;
    logic [7:0] rd_m;
    logic [7:0] exp_q [$];

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            s_m[b] = UNITY;
            t_m[b] = UNITY;
            c_m[b] = UNITY;
        end
        byp_m  = 1'b0;
        busy_m = 1'b0;
        rd_m   = 8'h00;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        if (a < 2 * NB) return (a % 2 == 0) ? 8'(s_m[a/2] % 256) : 8'(s_m[a/2] / 256);
        if (a == 'hF1) return 8'(byp_m);
        if (a == 'hF2) return 8'(busy_m);
        return 8'h00;
    endfunction

    function automatic void model_step(input bit w, input bit r, input int a, input int d, input bit t);
        bit any_diff;
        if (r) rd_m = model_read(a);
`ifdef GAIN_RAMP_EN
        any_diff = 1'b0;
        for (int b = 0; b < NB; b++) if (c_m[b] != t_m[b]) any_diff = 1'b1;
        if (t) begin
            for (int b = 0; b < NB; b++) begin
                if (c_m[b] < t_m[b])      c_m[b] += (t_m[b] - c_m[b] < RS) ? t_m[b] - c_m[b] : RS;
                else if (c_m[b] > t_m[b]) c_m[b] -= (c_m[b] - t_m[b] < RS) ? c_m[b] - t_m[b] : RS;
            end
        end
        busy_m = any_diff;
`else
        any_diff = 1'b0;
        busy_m   = any_diff;
`endif
        if (w) begin
            if (a < 2 * NB) begin
                if (a % 2 == 0) s_m[a/2] = (s_m[a/2] / 256) * 256 + d;
                else            s_m[a/2] = (s_m[a/2] % 256) + (d & HMASK) * 256;
            end else if (a == 'hF0) begin
                if (d % 2 == 1) for (int b = 0; b < NB; b++) t_m[b] = s_m[b];
                if ((d / 2) % 2 == 1) for (int b = 0; b < NB; b++) s_m[b] = UNITY;
            end else if (a == 'hF1) begin
                byp_m = d[0];
            end
        end
`ifndef GAIN_RAMP_EN
        for (int b = 0; b < NB; b++) c_m[b] = t_m[b];
`endif
    endfunction

    function automatic logic [GW-1:0] dut_gain(input int b);
        return bus.gain[b*GW +: GW];
    endfunction

    // driver tasks
    task automatic drive_cycle(input bit w, input bit r, input logic [7:0] a, input logic [7:0] d, input bit t);
        bus.we = w; bus.re = r; bus.addr = a; bus.data_in = d; bus.tick = t;
        @(posedge clk);
        model_step(w, r, int'(a), int'(d), t);
        #1;
        bus.we = 1'b0; bus.re = 1'b0; bus.tick = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        drive_cycle(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic read_reg(input logic [7:0] a);
        drive_cycle(1'b0, 1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = 8'h00; bus.data_in = 8'h00; bus.tick = 1'b1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int b = 0; b < NB; b++) begin
            n_checks++;
            if (dut_gain(b) !== GW'(UNITY)) $display("FAIL reset_gain band=%0d actual=%0d expected=%0d", b, dut_gain(b), UNITY);
            else n_pass++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy actual=%b expected=0", bus.busy);
        else n_pass++;
        n_checks++;
        if (bus.rd_data !== 8'h00) $display("FAIL reset_rd_data actual=%h expected=00", bus.rd_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.tick = 1'b0;
        for (int a = 0; a < 2 * NB; a++) begin
            read_reg(8'(a));
            n_checks++;
            if (bus.rd_data !== ((a % 2 == 0) ? 8'h00 : 8'h01))
                $display("FAIL reset_readback addr=%0d actual=%h expected=%h", a, bus.rd_data, (a % 2 == 0) ? 8'h00 : 8'h01);
            else n_pass++;
        end
    endtask

    task automatic test_stage_commit();
        write_reg(8'd4, 8'h80);
        write_reg(8'd5, 8'h03);
        n_checks++;
        if (dut_gain(2) !== GW'(256)) $display("FAIL staged_no_commit actual=%0d expected=256", dut_gain(2));
        else n_pass++;
        read_reg(8'd4);
        n_checks++;
        if (bus.rd_data !== 8'h80) $display("FAIL stage_read_lo actual=%h expected=80", bus.rd_data);
        else n_pass++;
        read_reg(8'd5);
        n_checks++;
        if (bus.rd_data !== 8'h03) $display("FAIL stage_read_hi actual=%h expected=03", bus.rd_data);
        else n_pass++;
        write_reg(8'hF0, 8'h01);
`ifdef GAIN_RAMP_EN
        n_checks++;
        if (dut_gain(2) !== GW'(256)) $display("FAIL commit_no_tick actual=%0d expected=256", dut_gain(2));
        else n_pass++;
        tick_n(45);
`endif
        n_checks++;
        if (dut_gain(2) !== GW'(896)) $display("FAIL commit_gain actual=%0d expected=896", dut_gain(2));
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL commit_busy_settled actual=%b expected=0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_ramp();
        int seq [3] = '{272, 288, 300};
        write_reg(8'd0, 8'h2C);
        write_reg(8'd1, 8'h01);
        write_reg(8'hF0, 8'h01);
`ifdef GAIN_RAMP_EN
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            n_checks++;
            if (dut_gain(0) !== GW'(seq[i])) $display("FAIL ramp_up step=%0d actual=%0d expected=%0d", i, dut_gain(0), seq[i]);
            else n_pass++;
            n_checks++;
            if (bus.busy !== 1'b1) $display("FAIL ramp_busy step=%0d actual=%b expected=1", i, bus.busy);
            else n_pass++;
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL ramp_busy_fall actual=%b expected=0", bus.busy);
        else n_pass++;
        write_reg(8'd0, 8'h00);
        write_reg(8'd1, 8'h00);
        write_reg(8'hF0, 8'h01);
        tick_n(18);
        n_checks++;
        if (dut_gain(0) !== GW'(12)) $display("FAIL ramp_down_18 actual=%0d expected=12", dut_gain(0));
        else n_pass++;
        tick_n(1);
        n_checks++;
        if (dut_gain(0) !== GW'(0)) $display("FAIL ramp_down_19 actual=%0d expected=0", dut_gain(0));
        else n_pass++;
        tick_n(1);
`else
        n_checks++;
        if (dut_gain(0) !== GW'(300)) $display("FAIL direct_commit actual=%0d expected=300", dut_gain(0));
        else n_pass++;
        write_reg(8'd0, 8'h00);
        write_reg(8'd1, 8'h00);
        write_reg(8'hF0, 8'h01);
        tick_n(3);
`endif
        n_checks++;
        if (dut_gain(0) !== GW'(0)) $display("FAIL ramp_no_wrap actual=%0d expected=0", dut_gain(0));
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL busy_after_ramp actual=%b expected=0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_retarget_and_reset();
`ifdef GAIN_RAMP_EN
        int seq [3] = '{284, 268, 260};
        write_reg(8'd0, 8'h2C);
        write_reg(8'd1, 8'h01);
        write_reg(8'hF0, 8'h01);
        tick_n(18);
        n_checks++;
        if (dut_gain(0) !== GW'(288)) $display("FAIL retarget_start actual=%0d expected=288", dut_gain(0));
        else n_pass++;
        write_reg(8'd0, 8'h04);
        write_reg(8'd1, 8'h01);
        drive_cycle(1'b1, 1'b0, 8'hF0, 8'h01, 1'b1);
        n_checks++;
        if (dut_gain(0) !== GW'(300)) $display("FAIL retarget_old_target actual=%0d expected=300", dut_gain(0));
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            n_checks++;
            if (dut_gain(0) !== GW'(seq[i])) $display("FAIL retarget step=%0d actual=%0d expected=%0d", i, dut_gain(0), seq[i]);
            else n_pass++;
        end
        write_reg(8'd0, 8'h00);
        write_reg(8'd1, 8'h00);
        write_reg(8'hF0, 8'h01);
        tick_n(2);
        n_checks++;
        if (dut_gain(0) !== GW'(228)) $display("FAIL mid_ramp_value actual=%0d expected=228", dut_gain(0));
        else n_pass++;
`else
        write_reg(8'd0, 8'h04);
        write_reg(8'd1, 8'h01);
        drive_cycle(1'b1, 1'b0, 8'hF0, 8'h01, 1'b1);
        n_checks++;
        if (dut_gain(0) !== GW'(260)) $display("FAIL commit_with_tick actual=%0d expected=260", dut_gain(0));
        else n_pass++;
`endif
        rst = 1'b1;
        model_reset();
        #1;
        for (int b = 0; b < NB; b++) begin
            n_checks++;
            if (dut_gain(b) !== GW'(UNITY)) $display("FAIL async_reset_gain band=%0d actual=%0d expected=%0d", b, dut_gain(b), UNITY);
            else n_pass++;
        end
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL async_reset_busy actual=%b expected=0", bus.busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bypass_unmapped();
        write_reg(8'd2, 8'h40);
        write_reg(8'd3, 8'h02);
        write_reg(8'd6, 8'h10);
        write_reg(8'd7, 8'h00);
        write_reg(8'hF0, 8'h01);
        tick_n(25);
        write_reg(8'hF1, 8'h01);
        for (int b = 0; b < NB; b++) begin
            n_checks++;
            if (dut_gain(b) !== GW'(UNITY)) $display("FAIL bypass_gain band=%0d actual=%0d expected=%0d", b, dut_gain(b), UNITY);
            else n_pass++;
        end
        read_reg(8'hF1);
        n_checks++;
        if (bus.rd_data !== 8'h01) $display("FAIL bypass_read actual=%h expected=01", bus.rd_data);
        else n_pass++;
        write_reg(8'hF1, 8'h00);
        n_checks++;
        if (dut_gain(1) !== GW'(576)) $display("FAIL unbypass_band1 actual=%0d expected=576", dut_gain(1));
        else n_pass++;
        n_checks++;
        if (dut_gain(3) !== GW'(16)) $display("FAIL unbypass_band3 actual=%0d expected=16", dut_gain(3));
        else n_pass++;
        read_reg(8'd2);
        read_reg(8'h50);
        n_checks++;
        if (bus.rd_data !== 8'h00) $display("FAIL unmapped_read actual=%h expected=00", bus.rd_data);
        else n_pass++;
        write_reg(8'h50, 8'hFF);
        read_reg(8'hF0);
        n_checks++;
        if (bus.rd_data !== 8'h00) $display("FAIL ctrl_read actual=%h expected=00", bus.rd_data);
        else n_pass++;
        for (int a = 0; a < 2 * NB; a++) begin
            read_reg(8'(a));
            n_checks++;
            if (bus.rd_data !== rd_m) $display("FAIL unmapped_write_side_effect addr=%0d actual=%h expected=%h", a, bus.rd_data, rd_m);
            else n_pass++;
        end
    endtask

    task automatic test_high_byte_ctrl3();
        write_reg(8'd7, 8'hFF);
        read_reg(8'd7);
        n_checks++;
        if (bus.rd_data !== 8'h1F) $display("FAIL high_byte_mask actual=%h expected=1f", bus.rd_data);
        else n_pass++;
        write_reg(8'd6, 8'hAA);
        write_reg(8'hF0, 8'h03);
        read_reg(8'd6);
        n_checks++;
        if (bus.rd_data !== 8'h00) $display("FAIL ctrl3_stage_lo actual=%h expected=00", bus.rd_data);
        else n_pass++;
        read_reg(8'd7);
        n_checks++;
        if (bus.rd_data !== 8'h01) $display("FAIL ctrl3_stage_hi actual=%h expected=01", bus.rd_data);
        else n_pass++;
`ifdef GAIN_RAMP_EN
        tick_n(520);
`endif
        n_checks++;
        if (dut_gain(3) !== GW'(8106)) $display("FAIL ctrl3_commit_old actual=%0d expected=8106", dut_gain(3));
        else n_pass++;
        n_checks++;
        if (bus.busy !== 1'b0) $display("FAIL ctrl3_busy actual=%b expected=0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] exp;
        bit         w;
        bit         r;
        bit         t;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 8'($urandom_range(0, 2 * NB - 1));
                5:             a = 8'hF0;
                6:             a = 8'hF1;
                7:             a = 8'hF2;
                default:       a = 8'($urandom_range(0, 255));
            endcase
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 1);
            t = ($urandom_range(0, 2) == 0);
            drive_cycle(w, r, a, 8'($urandom_range(0, 255)), t);
            if (r) begin
                exp_q.push_back(rd_m);
                exp = exp_q.pop_front();
                n_checks++;
                if (bus.rd_data !== exp) $display("FAIL rand_read cyc=%0d addr=%h actual=%h expected=%h", i, a, bus.rd_data, exp);
                else n_pass++;
            end
            n_checks++;
            if (bus.busy !== busy_m) $display("FAIL rand_busy cyc=%0d actual=%b expected=%b", i, bus.busy, busy_m);
            else n_pass++;
            for (int b = 0; b < NB; b++) begin
                n_checks++;
                if (dut_gain(b) !== GW'(byp_m ? UNITY : c_m[b]))
                    $display("FAIL rand_gain cyc=%0d band=%0d actual=%0d expected=%0d", i, b, dut_gain(b), byp_m ? UNITY : c_m[b]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stage_commit();
        test_ramp();
        test_retarget_and_reset();
        test_bypass_unmapped();
        test_high_byte_ctrl3();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/eq_gain_regbank.md
# eq_gain_regbank

Parametrised band-gain register bank for the digital audio equalizer, successor to the fixed 10-band gain map. It holds a host-writable staging copy of every band gain and transfers all staged gains atomically to the active set on a commit command. Active gains optionally ramp toward their targets, one step per audio sample tick, to suppress zipper noise. Its flattened gain bus feeds the per-band multipliers of the filter bank.

## Interface
- NUM_BANDS, 10, number of equalizer bands (1..64)
- GAIN_WIDTH, 13, unsigned gain width, 9..16
- FRAC_BITS, 8, fractional bits; Q5.8 with the defaults; unity = 1 << FRAC_BITS
- RAMP_STEP, 16, maximum change in LSBs per tick when ramping
- clk  in  1  system clock, all state on the rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write strobe, one byte per cycle
- re  in  1  read strobe
- addr  in  8  register byte address
- data_in  in  8  write data
- tick  in  1  one-cycle audio sample strobe
- rd_data  out  8  read data, registered
- gain  out  NUM_BANDS*GAIN_WIDTH  active gains; band b at [b*GAIN_WIDTH +: GAIN_WIDTH]
- busy  out  1  high while any active gain differs from its target

## Operation
- Band b has three registers: staging S[b], target T[b], and current C[b]. Outputs drive C[b].
- Address map:
  - 2b: S[b][7:0].
  - 2b+1: S[b][GAIN_WIDTH-1:8]; data_in bits above GAIN_WIDTH-9 are ignored on write and read back as 0.
  - 0xF0 CTRL, write-only; reads return 0.
    - bit0 = COMMIT: all T[b] <= S[b] simultaneously.
    - bit1 = STAGE_UNITY: all S[b] <= unity.
    - If both bits are set, COMMIT uses the old S; S becomes unity afterwards.
  - 0xF1 BYPASS, R/W; bit0 = 1 forces every gain output to unity. C and T are unaffected; busy is still reported.
  - 0xF2 STATUS, read-only; bit0 = busy.
- Writes to any other address are ignored; reads of any other address return 0x00.
- Reset:
  - S, T and C all reset to unity (256).
  - BYPASS resets to 0; rd_data resets to 0; busy resets to 0.
  - Reset mid-ramp or mid-read aborts immediately.
- Ramp, with GAIN_RAMP_EN defined; applies on each cycle with tick = 1, to every band independently:
  - If C < T: C <= C + min(RAMP_STEP, T-C).
  - If C > T: C <= C - min(RAMP_STEP, C-T).
  - Arithmetic is unsigned in GAIN_WIDTH+1 bits, so C never overshoots and never wraps.
  - A commit during a ramp retargets the ramp from the present C.
- busy = OR over all b of (C[b] != T[b]); it is a registered output.

## Timing
- Write: S, CTRL and BYPASS update on the edge where we = 1. gain changes no earlier than the edge that applies a commit.
- Without ramp: the commit edge sets T; C follows on the same edge, so gain changes 1 cycle after the we cycle. busy is constantly 0.
- With ramp:
  - C steps only on tick edges.
  - If COMMIT and tick coincide, that edge steps toward the old T; the new T is used from the next tick.
  - busy rises on the edge after a commit that creates a mismatch. It falls on the edge after the last step.
- Read: rd_data is valid the cycle after re = 1; otherwise it holds its previous value.
- If we and re are asserted to the same address in the same cycle, rd_data returns the pre-write value.
- tick during reset is ignored.

## Configuration
- GAIN_RAMP_EN:
  - Defined: the ramp engine and the RAMP_STEP behaviour are present.
  - Undefined: C is the same register as T, COMMIT is instantaneous, busy is tied to 0 and STATUS reads 0.
- The address map is identical either way.

## Test plan
- Reset, then read all bands: S bytes read 0x00 / 0x01, gain = 256 for every band, busy = 0, rd_data = 0.
- Write band 2 as 0x80 then 0x03 (0x380 = 896), no commit -> gain band 2 stays 256. Readback returns 0x80 and 0x03. Then write CTRL = 0x01 -> band 2 target = 896.
- Ramp on (RAMP_STEP = 16), commit 256 -> 300: ticks move C 256, 272, 288, 300 (last step clamped); busy falls after the third tick. Committing 300 -> 0 takes 19 ticks and ends exactly at 0 with no wrap.
- Mid-ramp retarget: at C = 288 commit T = 260 in the same cycle as a tick -> C = 300, then 284, 268, 260. Also assert rst mid-ramp -> all outputs return to 256 immediately.
- Write BYPASS = 1 with band gains ≠ 256 -> every gain = 256. Clear it -> prior values return. Reading unmapped 0x50 -> 0x00; a write there changes nothing.
- Write high byte 0xFF with GAIN_WIDTH = 13 -> reads back 0x1F. CTRL = 0x03 commits the old S and leaves S at unity.
